// File: rtl/store_commit_queue.sv
// store_commit_queue: in-order store queue that holds destructive memory ops
// until their instruction id retires, then drains committed heads in order.
// Optional store-to-load forwarding search: define SQ_FORWARD_EN.

package store_commit_queue_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [2:0]  fn3;
        logic [31:0] data;
        logic [1:0]  subunit;
        logic        is_amo;
        logic [4:0]  amo_type;
    } sq_entry_t;
endpackage

module store_commit_queue
    import store_commit_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ID_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enq_valid,
    output logic            enq_ready,
    input  logic [ID_W-1:0] enq_id,
    input  sq_entry_t       enq_entry,
    input  logic            retire_valid,
    input  logic [ID_W-1:0] retire_id,
    input  logic            flush,
    output logic            out_valid,
    output sq_entry_t       out_entry,
    input  logic            out_ready,
    output logic            sq_empty,
    output logic            no_commited_ops_pending,
    input  logic [31:0]     fwd_addr,
    output logic            fwd_hit,
    output logic [31:0]     fwd_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] committed;
    logic [ID_W-1:0]  ids     [DEPTH];
    sq_entry_t        entries [DEPTH];

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             full;
    logic             enq_fire;
    logic             deq_fire;
    logic             enq_commit;
    logic [DEPTH-1:0] commit_nxt;
    logic [PTR_W-1:0] keep_cnt;

    assign head_idx   = head[IDX_W-1:0];
    assign tail_idx   = tail[IDX_W-1:0];
    assign full       = (head_idx == tail_idx) && (head[PTR_W-1] != tail[PTR_W-1]);
    assign enq_ready  = ~full;
    assign enq_fire   = enq_valid & ~full & ~flush;
    assign out_valid  = valid[head_idx] & committed[head_idx];
    assign out_entry  = entries[head_idx];
    assign deq_fire   = out_valid & out_ready;
    assign enq_commit = retire_valid && (retire_id == enq_id);

    assign sq_empty                = (head == tail);
    assign no_commited_ops_pending = ~|(valid & committed);

    // Committed view after this cycle's retire, and how many entries survive a flush
    always_comb begin
        commit_nxt = '0;
        keep_cnt   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            commit_nxt[i] = committed[i] | (valid[i] & retire_valid & (ids[i] == retire_id));
            if (valid[i] && commit_nxt[i]) begin
                keep_cnt = keep_cnt + PTR_W'(1);
            end
        end
    end

    // Pointer and per-entry status bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            valid     <= '0;
            committed <= '0;
        end else begin
            committed <= commit_nxt & valid;
            if (flush) begin
                // Committed entries are contiguous from head, so tail rolls back to just past them
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid[i] && !commit_nxt[i]) begin
                        valid[i]     <= 1'b0;
                        committed[i] <= 1'b0;
                    end
                end
                tail <= head + keep_cnt;
            end else if (enq_fire) begin
                valid[tail_idx]     <= 1'b1;
                committed[tail_idx] <= enq_commit;
                tail                <= tail + PTR_W'(1);
            end
            if (deq_fire) begin
                valid[head_idx]     <= 1'b0;
                committed[head_idx] <= 1'b0;
                head                <= head + PTR_W'(1);
            end
        end
    end

    // Payload storage, written only on accepted enqueue
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            ids[tail_idx]     <= enq_id;
            entries[tail_idx] <= enq_entry;
        end
    end

`ifdef SQ_FORWARD_EN
    // Youngest matching store wins: scan oldest to youngest, later hits override
    always_comb begin : fwd_search
        logic [IDX_W-1:0] fidx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fidx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fidx = head_idx + IDX_W'(i);
            if (valid[fidx] && (entries[fidx].addr[31:2] == fwd_addr[31:2]) &&
                (entries[fidx].be != 4'h0)) begin
                fwd_hit  = 1'b1;
                fwd_data = entries[fidx].data;
            end
        end
    end
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^fwd_addr;
    assign fwd_hit         = 1'b0;
    assign fwd_data        = '0;
`endif

endmodule
